spi_tx: RTL

- Serial transmitter that feeds the serial receiver stage. It accepts parallel bytes over a valid/ready handshake and buffers them in a small FIFO.
- It shifts each byte out MSB first, one bit per rising clk edge. It outputs a flush pulse so the receiver can drop a partially received byte when a transfer is aborted.

---
 rtl/spi_tx.sv | 118 +++++++++++
 1 files changed

// File: rtl/spi_tx.sv
// Byte-serial transmitter: valid/ready write side into a small FIFO, MSB-first shifter out,
// with a flush pulse so the downstream receiver can drop a partial word after an abort.
module spi_tx #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         data_in,
   input  logic                     data_valid,
   output logic                     data_ready,
   input  logic                     abort,
   output logic                     bit_out,
   output logic                     bit_valid,
   output logic                     first_bit,
   output logic                     last_bit,
   output logic                     flush_out,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     wr_ptr;
   logic [WIDTH-1:0]  shift_reg;
   logic [CW-1:0]     cnt;
   logic [WIDTH-1:0]  head;
   logic              push;
   logic              pop;
   logic              word_end;

   // Ready depends only on reset and the registered occupancy, so a full FIFO refuses a
   // push even on the edge that also pops.
   assign data_ready = !rst && (level != FULL);
   assign push       = data_valid && data_ready;
   assign word_end   = (state == SHIFT) && (cnt == LAST);
   assign pop        = !abort && (level != '0) && ((state == IDLE) || word_end);
   assign head       = mem[rd_ptr];
   assign bit_out    = shift_reg[WIDTH-1];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level + LW'(push) - LW'(pop);
      end
   end

   // The shift register is cleared whenever the shifter idles, so bit_out reads 0 there.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         shift_reg <= '0;
         cnt       <= '0;
         flush_out <= 1'b0;
         bit_valid <= 1'b0;
         first_bit <= 1'b0;
         last_bit  <= 1'b0;
      end else begin
         flush_out <= 1'b0;
         if (abort) begin
            if (state == SHIFT) begin
               state     <= IDLE;
               shift_reg <= '0;
               cnt       <= '0;
               flush_out <= 1'b1;
               bit_valid <= 1'b0;
               first_bit <= 1'b0;
               last_bit  <= 1'b0;
            end
         end else if (pop) begin
            state     <= SHIFT;
            shift_reg <= head;
            cnt       <= '0;
            bit_valid <= 1'b1;
            first_bit <= 1'b1;
            last_bit  <= (WIDTH == 1);
         end else if (state == SHIFT) begin
            if (cnt == LAST) begin
               state     <= IDLE;
               shift_reg <= '0;
               cnt       <= '0;
               bit_valid <= 1'b0;
               first_bit <= 1'b0;
               last_bit  <= 1'b0;
            end else begin
               shift_reg <= shift_reg << 1;
               cnt       <= cnt + CW'(1);
               first_bit <= 1'b0;
               last_bit  <= (cnt == LAST - CW'(1));
            end
         end
      end
   end

endmodule
